// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - reservation-station issue queue with CDB wakeup and multi-port select
// Optional ISSUE_AGE_SELECT_EN: oldest-first select via an age matrix; otherwise lowest index first.
module issue_queue #(
   parameter int RS_DEPTH   = 16,
   parameter int DISPATCH_W = 4,
   parameter int ISSUE_W    = 2,
   parameter int CDB_W      = 4,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 6,
   parameter int OP_W       = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic [DISPATCH_W-1:0]                 disp_valid,
   input  logic [DISPATCH_W-1:0][OP_W-1:0]       disp_op,
   input  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_dst,
   input  logic [DISPATCH_W-1:0][DATA_W-1:0]     disp_v1,
   input  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_q1,
   input  logic [DISPATCH_W-1:0]                 disp_r1,
   input  logic [DISPATCH_W-1:0][DATA_W-1:0]     disp_v2,
   input  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_q2,
   input  logic [DISPATCH_W-1:0]                 disp_r2,
   output logic                                  disp_ready,
   input  logic [CDB_W-1:0]                      cdb_valid,
   input  logic [CDB_W-1:0][TAG_W-1:0]           cdb_tag,
   input  logic [CDB_W-1:0][DATA_W-1:0]          cdb_val,
   output logic [ISSUE_W-1:0]                    iss_valid,
   input  logic [ISSUE_W-1:0]                    iss_ready,
   output logic [ISSUE_W-1:0][OP_W-1:0]          iss_op,
   output logic [ISSUE_W-1:0][DATA_W-1:0]        iss_v1,
   output logic [ISSUE_W-1:0][DATA_W-1:0]        iss_v2,
   output logic [ISSUE_W-1:0][TAG_W-1:0]         iss_dst,
   output logic [$clog2(RS_DEPTH):0]             occupancy
);
   localparam int IDX_W  = $clog2(RS_DEPTH);
   localparam int CNT_W  = IDX_W + 1;
   localparam int SLOT_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

   logic [RS_DEPTH-1:0] busy;
   logic [RS_DEPTH-1:0] rdy1;
   logic [RS_DEPTH-1:0] rdy2;
   logic [OP_W-1:0]     op_q  [RS_DEPTH];
   logic [TAG_W-1:0]    dst_q [RS_DEPTH];
   logic [DATA_W-1:0]   v1_q  [RS_DEPTH];
   logic [DATA_W-1:0]   v2_q  [RS_DEPTH];
   logic [TAG_W-1:0]    q1_q  [RS_DEPTH];
   logic [TAG_W-1:0]    q2_q  [RS_DEPTH];

   // Returns {hit, value}; scanning downward lets the lowest matching channel win.
   function automatic logic [DATA_W:0] cdb_lookup(
      input logic [TAG_W-1:0]                tag,
      input logic [CDB_W-1:0]                vld,
      input logic [CDB_W-1:0][TAG_W-1:0]     tags,
      input logic [CDB_W-1:0][DATA_W-1:0]    vals
   );
      logic [DATA_W:0] res;
      res = '0;
      for (int c = CDB_W - 1; c >= 0; c--) begin
         if (vld[c] && tags[c] == tag) res = {1'b1, vals[c]};
      end
      return res;
   endfunction

   logic [DATA_W:0] wk1 [RS_DEPTH];
   logic [DATA_W:0] wk2 [RS_DEPTH];
   logic [DATA_W:0] bp1 [DISPATCH_W];
   logic [DATA_W:0] bp2 [DISPATCH_W];

   always_comb begin
      for (int e = 0; e < RS_DEPTH; e++) begin
         wk1[e] = cdb_lookup(q1_q[e], cdb_valid, cdb_tag, cdb_val);
         wk2[e] = cdb_lookup(q2_q[e], cdb_valid, cdb_tag, cdb_val);
      end
      for (int s = 0; s < DISPATCH_W; s++) begin
         bp1[s] = cdb_lookup(disp_q1[s], cdb_valid, cdb_tag, cdb_val);
         bp2[s] = cdb_lookup(disp_q2[s], cdb_valid, cdb_tag, cdb_val);
      end
   end

   always_comb begin
      occupancy = '0;
      for (int e = 0; e < RS_DEPTH; e++) occupancy = occupancy + CNT_W'(busy[e]);
   end

   assign disp_ready = (CNT_W'(RS_DEPTH) - occupancy) >= CNT_W'(DISPATCH_W);

   logic                do_disp;
   logic [RS_DEPTH-1:0] new_mask;
   logic [SLOT_W-1:0]   new_slot [RS_DEPTH];

   assign do_disp = disp_ready & (|disp_valid) & ~flush;

   // Walk valid slots in order, each claiming the lowest still-free entry.
   always_comb begin
      logic [RS_DEPTH-1:0] taken;
      logic                found;
      taken    = busy;
      found    = 1'b0;
      new_mask = '0;
      for (int e = 0; e < RS_DEPTH; e++) new_slot[e] = '0;
      for (int s = 0; s < DISPATCH_W; s++) begin
         found = 1'b0;
         if (disp_valid[s] && do_disp) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
               if (!found && !taken[e]) begin
                  found       = 1'b1;
                  taken[e]    = 1'b1;
                  new_mask[e] = 1'b1;
                  new_slot[e] = SLOT_W'(s);
               end
            end
         end
      end
   end

`ifdef ISSUE_AGE_SELECT_EN
   // older[i][j] set means entry i was dispatched before entry j.
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older;

   always_ff @(posedge clk) begin
      if (rst) begin
         older <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
               if (new_mask[i])
                  older[i][j] <= new_mask[j] && (new_slot[j] > new_slot[i]);
               else if (new_mask[j])
                  older[i][j] <= 1'b1;
            end
         end
      end
   end
`endif

   logic [RS_DEPTH-1:0] issue_clr;

   always_comb begin
      logic [RS_DEPTH-1:0] cand;
      logic                pick;
      logic [IDX_W-1:0]    pidx;
`ifdef ISSUE_AGE_SELECT_EN
      logic                oldest;
      oldest = 1'b0;
`endif
      cand      = busy & rdy1 & rdy2;
      issue_clr = '0;
      iss_valid = '0;
      iss_op    = '0;
      iss_v1    = '0;
      iss_v2    = '0;
      iss_dst   = '0;
      pick      = 1'b0;
      pidx      = '0;
      for (int p = 0; p < ISSUE_W; p++) begin
         pick = 1'b0;
         pidx = '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef ISSUE_AGE_SELECT_EN
            oldest = cand[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
               if (cand[j] && older[j][i]) oldest = 1'b0;
            end
            if (oldest && !pick) begin
               pick = 1'b1;
               pidx = IDX_W'(i);
            end
`else
            if (cand[i] && !pick) begin
               pick = 1'b1;
               pidx = IDX_W'(i);
            end
`endif
         end
         if (pick) begin
            iss_valid[p] = 1'b1;
            iss_op[p]    = op_q[pidx];
            iss_v1[p]    = v1_q[pidx];
            iss_v2[p]    = v2_q[pidx];
            iss_dst[p]   = dst_q[pidx];
            cand[pidx]   = 1'b0;
            if (iss_ready[p]) issue_clr[pidx] = 1'b1;
         end
      end
   end

   // Dispatch only targets entries that are free in registered state, so it never collides with issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         rdy1 <= '0;
         rdy2 <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         for (int e = 0; e < RS_DEPTH; e++) begin
            if (new_mask[e]) begin
               busy[e]  <= 1'b1;
               op_q[e]  <= disp_op[new_slot[e]];
               dst_q[e] <= disp_dst[new_slot[e]];
               q1_q[e]  <= disp_q1[new_slot[e]];
               q2_q[e]  <= disp_q2[new_slot[e]];
               rdy1[e]  <= disp_r1[new_slot[e]] | bp1[new_slot[e]][DATA_W];
               rdy2[e]  <= disp_r2[new_slot[e]] | bp2[new_slot[e]][DATA_W];
               v1_q[e]  <= (!disp_r1[new_slot[e]] && bp1[new_slot[e]][DATA_W]) ?
                           bp1[new_slot[e]][DATA_W-1:0] : disp_v1[new_slot[e]];
               v2_q[e]  <= (!disp_r2[new_slot[e]] && bp2[new_slot[e]][DATA_W]) ?
                           bp2[new_slot[e]][DATA_W-1:0] : disp_v2[new_slot[e]];
            end else begin
               if (issue_clr[e]) busy[e] <= 1'b0;
               if (busy[e] && !rdy1[e] && wk1[e][DATA_W]) begin
                  rdy1[e] <= 1'b1;
                  v1_q[e] <= wk1[e][DATA_W-1:0];
               end
               if (busy[e] && !rdy2[e] && wk2[e][DATA_W]) begin
                  rdy2[e] <= 1'b1;
                  v2_q[e] <= wk2[e][DATA_W-1:0];
               end
            end
         end
      end
   end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter RS_DEPTH, default 16, number of queue entries (>= DISPATCH_W, power of two).
REQ-002 Parameter DISPATCH_W, default 4, dispatch slots per cycle.
REQ-003 Parameter ISSUE_W, default 2, issue ports to functional units (1..4).
REQ-004 Parameter CDB_W, default 4, CDB broadcast channels.
REQ-005 Parameters DATA_W (default 32, operand width), TAG_W (default 6, physical tag width), OP_W (default 32, opcode word width).
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  discard all entries.
REQ-009 disp_valid  input  DISPATCH_W  per-slot instruction valid.
REQ-010 disp_op/disp_dst  input  DISPATCH_W x OP_W / x TAG_W  opcode, destination tag.
REQ-011 disp_v1/disp_q1/disp_r1, disp_v2/disp_q2/disp_r2  input  DISPATCH_W x DATA_W/TAG_W/1  operand value, source tag, ready flag.
REQ-012 disp_ready  output  1  queue accepts the whole dispatch group this cycle.
REQ-013 cdb_valid  input  CDB_W; cdb_tag  input  CDB_W x TAG_W; cdb_val  input  CDB_W x DATA_W  result broadcasts.
REQ-014 iss_valid  output  ISSUE_W; iss_ready  input  ISSUE_W  per-port issue handshake.
REQ-015 iss_op/iss_v1/iss_v2/iss_dst  output  ISSUE_W x OP_W/DATA_W/DATA_W/TAG_W  issued payload.
REQ-016 occupancy  output  $clog2(RS_DEPTH)+1  count of busy entries.

Function
REQ-017 disp_ready SHALL be 1 iff free entries >= DISPATCH_W, from registered busy state only (entries freed this cycle not counted).
REQ-018 Dispatch fire = disp_ready & any disp_valid & ~flush; each valid slot written to a distinct free entry, lowest free index to lowest valid slot; invalid slots consume nothing.
REQ-019 Entry eligible iff busy and both operand ready flags set in registered state; wakeup visible to select one cycle after CDB match.
REQ-020 CDB match (valid, tag equal, operand not ready) SHALL set ready and capture cdb_val at the clock edge; multiple channels matching same tag: lowest channel wins.
REQ-021 Dispatch bypass: a dispatched operand with r=0 whose q matches a same-cycle CDB channel SHALL be stored ready with that CDB value.
REQ-022 Select: up to ISSUE_W distinct eligible entries, port 0 gets highest priority, port k the (k+1)-th; iss_valid/payload combinational from registered state.
REQ-023 Priority order: oldest-first when ISSUE_AGE_SELECT_EN defined, else lowest index first.
REQ-024 Age: dispatch slot i older than slot j>i in the same group; any resident entry older than all newly dispatched.
REQ-025 Issue fire (iss_valid & iss_ready) SHALL clear that entry's busy at the edge; port with iss_ready=0 holds its grant stable next cycle unless a higher-priority entry becomes eligible.
REQ-026 Ports with no eligible entry: iss_valid=0, payload 0.
REQ-027 flush SHALL clear all busy at the edge, overriding dispatch and wakeup; iss_valid still reflects pre-flush state that cycle.
REQ-028 Full queue: disp_ready=0, state unchanged except wakeup/issue; occupancy never exceeds RS_DEPTH.
REQ-029 occupancy(next) = occupancy + dispatched - issued (0 after flush).

Reset
REQ-030 On rst=1 at an edge: all busy/ready/age state cleared; occupancy=0, iss_valid=0, disp_ready=1; rst mid-operation drops all entries, identical to flush, and overrides flush/dispatch.

Configuration
REQ-031 Macro ISSUE_AGE_SELECT_EN: defined -> RS_DEPTH x RS_DEPTH age matrix, oldest-first select; undefined -> no age storage, fixed lowest-index select; all other behaviour identical.

Verification
REQ-032 Reset, dispatch 4 ready ops (r1=r2=1) -> next cycle iss_valid=2'b11 on the two oldest, occupancy=4; with iss_ready=11, occupancy 2 then 0 over two cycles.
REQ-033 Dispatch op q1=5 r1=0; CDB tag 5 val 0xDEAD two cycles later -> iss_valid one cycle after CDB, iss_v1=0xDEAD.
REQ-034 Dispatch q1=7 r1=0 same cycle as CDB tag 7 val 0x1234 -> iss_valid next cycle with iss_v1=0x1234.
REQ-035 Fill to 13 of 16 entries -> disp_ready=0; issue one (freeing to 12) -> disp_ready=1 the cycle after, not before.
REQ-036 AGE_EN: entry index 9 dispatched before index 2, both ready -> port 0 gets index 9; without macro port 0 gets index 2.
REQ-037 flush with 10 busy and a simultaneous dispatch -> occupancy=0 next cycle, no issue from flushed entries.
